mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Sequencer for the single-ported unified instruction/data memory of the RV32IC core. It accepts a fetch request from the PC/fetch stage and a load/store request from the execute stage, and grants the one memory port to one of them at a time, data first. It splits 32-bit fetches at halfword-aligned addresses into two word accesses, and skips the second access when the first halfword is a compressed instruction. It also performs byte-lane steering and sign/zero extension for loads and stores, driven by the load/store func3 field.

## Interface
- AW, 12: memory word-address width (memory is 2^AW 32-bit words).
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held high with if_addr stable until if_ack.
- if_addr  in  AW+2  byte address of the fetch; bit 0 is ignored.
- if_ack  out  1  one-cycle pulse; if_instr is valid in this cycle.
- if_instr  out  32  fetched instruction; a 16-bit instruction is returned zero-extended.
- d_req  in  1  data request; held high with all d_* inputs stable until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_func  in  3  load/store func3: [1:0] 00 byte, 01 half, 10 word; [2] = unsigned load.
- d_addr  in  AW+2  byte address of the data access.
- d_wdata  in  32  store data, right-aligned.
- d_ack  out  1  one-cycle pulse that completes the data request.
- d_rdata  out  32  extended load data; valid while d_ack is high and d_err is 0; 0 for stores.
- d_err  out  1  asserted with d_ack for a misaligned access or a size code of 11; no memory access is made.
- mem_en  out  1  memory access strobe for this cycle.
- mem_we  out  4  byte write strobes; all zero for reads.
- mem_addr  out  AW  word address.
- mem_wdata  out  32  lane-steered store data.
- mem_rdata  in  32  synchronous memory read data; valid one cycle after mem_en.

## Operation
- FSM states: IDLE, D_WAIT, D_ERR, F_WAIT, F_LO, F_HI.
- IDLE with d_req high:
  - If the access is misaligned (half with addr[0] = 1, word with addr[1:0] != 0) or the size is 11: go to D_ERR.
  - Otherwise: issue mem_en with mem_addr = d_addr[AW+1:2]. For a store, mem_we is set per size and addr[1:0]. Go to D_WAIT.
- IDLE with if_req high and d_req low: issue word if_addr[AW+1:2].
  - if_addr[1] = 0: go to F_WAIT.
  - if_addr[1] = 1: go to F_LO.
- D_WAIT: pulse d_ack. A load returns the selected lane of mem_rdata, sign- or zero-extended per d_func[2]. Return to IDLE.
- D_ERR: pulse d_ack with d_err = 1 and d_rdata = 0. Return to IDLE.
- F_WAIT: pulse if_ack with if_instr = mem_rdata. Return to IDLE.
- F_LO: capture mem_rdata[31:16] into the hold register.
  - If mem_rdata[17:16] != 11 (compressed instruction): pulse if_ack with {16'h0, mem_rdata[31:16]} and return to IDLE.
  - Otherwise: issue word (w+1) mod 2^AW and go to F_HI.
- F_HI: pulse if_ack with {mem_rdata[15:0], hold}. Return to IDLE.
- Priority rules:
  - Arbitration happens only in IDLE; a transaction already in flight is never preempted.
  - A d_req that rises during a fetch is served at the next IDLE, ahead of any pending fetch.
- Store byte strobes:
  - byte: 0001 shifted by addr[1:0].
  - half: 0011 shifted by 2 × addr[1].
  - word: 1111.
  - mem_wdata is d_wdata replicated into the selected lanes.

## Timing
- Reset values: all outputs 0, state IDLE, hold register 0. Reset asserted mid-transaction abandons it with no ack; the requester must re-present its request after reset.
- mem_en is combinational from the state and requests, and is high only in issue cycles.
- Data access: issue in cycle N, d_ack in cycle N+1. The next issue is no earlier than N+2.
- Aligned fetch: ack at N+1.
- Split fetch: compressed instruction acks at N+1; full 32-bit instruction issues again at N+1 and acks at N+2.
- Wrap-around: a split fetch at the last word reads word 0 as its upper half.
- Requesters must not drop req before ack; behaviour if they do is undefined.

## Structure
- Shared package holds:
  - state encoding;
  - size codes BYTE = 00, HALF = 01, WORD = 10;
  - the RVC test constant 2'b11.
- One sub-module, lsu_lane_align: combinational; produces store strobes and steered data, load extraction and extension, and the misalignment flag. The FSM, address increment and hold register stay in mem_port_arbiter.

## Test plan
- Reset: with rst_n low, all outputs are 0. Release, then if_req with if_addr = 0x0 and mem word 0 = 0x00500093 → mem_addr = 0 at N, if_ack with if_instr = 0x00500093 at N+1.
- Split fetch:
  - if_addr = 0x6, word1 = 0x4505_xxxx: compressed, so if_ack at N+1 with 0x00004505 and no second mem_en.
  - word1 = 0x0093_xxxx, word2 = 0xxxxx_0050: if_ack at N+2 with 0x00500093.
- Loads with memory word 0x80F0_1234 at d_addr = 0x100/0x103: lb at 0x103 → 0xFFFFFF80; lbu at 0x103 → 0x00000080; lh at 0x100 → 0x00001234; lw at 0x100 → 0x80F01234.
- Stores and error: sb of d_wdata = 0xAB at 0x102 → mem_we = 0100, mem_wdata[23:16] = 0xAB. sw at 0x102 → no mem_en; d_ack with d_err = 1 next cycle.
- Simultaneous requests: if_req and d_req rise together → data is issued first and d_ack arrives before if_ack. Separately: split fetch at byte address 4·(2^AW − 1) + 2 → second issue has mem_addr = 0.
- Reset in F_HI: pull rst_n low → if_ack never pulses, state is IDLE, hold register is 0.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified-memory port arbiter of the RV32IC core:
// FSM state encoding, load/store size codes and the RVC opcode test value.
package mem_port_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_D_WAIT = 3'd1,
        ST_D_ERR  = 3'd2,
        ST_F_WAIT = 3'd3,
        ST_F_LO   = 3'd4,
        ST_F_HI   = 3'd5
    } state_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    // An instruction whose low two bits equal this value is a full 32-bit one.
    localparam logic [1:0] RVC_FULL = 2'b11;

    // Size code 11 is reserved and is rejected like a misaligned access.
    function automatic logic access_invalid(input logic [1:0] size,
                                            input logic [1:0] addr_lo);
        case (size)
            SIZE_BYTE: return 1'b0;
            SIZE_HALF: return addr_lo[0];
            SIZE_WORD: return addr_lo != 2'b00;
            default:   return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request, response and memory-bus signals of the port arbiter. The slave
// modport is the arbiter's view; the master modport is the requesters/memory.
interface mem_port_arbiter_if #(parameter int AW = 12);

    logic          if_req;
    logic [AW+1:0] if_addr;
    logic          if_ack;
    logic [31:0]   if_instr;

    logic          d_req;
    logic          d_we;
    logic [2:0]    d_func;
    logic [AW+1:0] d_addr;
    logic [31:0]   d_wdata;
    logic          d_ack;
    logic [31:0]   d_rdata;
    logic          d_err;

    logic          mem_en;
    logic [3:0]    mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_func, d_addr, d_wdata, mem_rdata,
        output if_ack, if_instr, d_ack, d_rdata, d_err,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_func, d_addr, d_wdata, mem_rdata,
        input  if_ack, if_instr, d_ack, d_rdata, d_err,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_port_arbiter_lsu_lane_align.sv
// Combinational byte-lane steering for loads and stores: store strobes and
// lane-replicated data, load lane extraction with sign/zero extension.
module lsu_lane_align
    import mem_port_arbiter_pkg::*;
(
    input  logic [2:0]  func,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] load_word,
    output logic [3:0]  byte_en,
    output logic [31:0] store_lanes,
    output logic [31:0] load_data,
    output logic        misaligned
);

    logic [31:0] replicated;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic        sign_ok;

    always_comb begin
        byte_en    = 4'b0000;
        replicated = 32'h0;
        load_data  = 32'h0;
        load_byte  = 8'h0;
        load_half  = 16'h0;
        sign_ok    = ~func[2];
        misaligned = access_invalid(func[1:0], addr_lo);

        case (addr_lo)
            2'd0:    load_byte = load_word[7:0];
            2'd1:    load_byte = load_word[15:8];
            2'd2:    load_byte = load_word[23:16];
            default: load_byte = load_word[31:24];
        endcase
        load_half = addr_lo[1] ? load_word[31:16] : load_word[15:0];

        case (func[1:0])
            SIZE_BYTE: begin
                byte_en    = 4'b0001 << addr_lo;
                replicated = {4{store_data[7:0]}};
                load_data  = {{24{sign_ok & load_byte[7]}}, load_byte};
            end
            SIZE_HALF: begin
                byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
                replicated = {2{store_data[15:0]}};
                load_data  = {{16{sign_ok & load_half[15]}}, load_half};
            end
            SIZE_WORD: begin
                byte_en    = 4'b1111;
                replicated = store_data;
                load_data  = load_word;
            end
            default: begin
                byte_en = 4'b0000;
            end
        endcase

        // Lanes not being written are driven as zero to keep the bus quiet.
        store_lanes = replicated & {{8{byte_en[3]}}, {8{byte_en[2]}},
                                    {8{byte_en[1]}}, {8{byte_en[0]}}};
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory sequencer: data requests win over fetches, halfword-
// aligned fetches are split into two word reads unless the first half is RVC.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW = 12
) (
    input  logic                clk,
    input  logic                rst_n,
    mem_port_arbiter_if.slave   bus
);

    state_t        state;
    state_t        state_next;
    logic [15:0]   hold;
    logic          hold_load;
    logic [AW-1:0] if_word;
    logic [AW-1:0] if_word_next;
    logic [AW-1:0] d_word;

    logic [3:0]    store_be;
    logic [31:0]   store_lanes;
    logic [31:0]   load_data;
    logic          lane_fault;

    logic          unused_ok;

    assign if_word      = bus.if_addr[AW+1:2];
    assign if_word_next = if_word + AW'(1);
    assign d_word       = bus.d_addr[AW+1:2];
    assign unused_ok    = &{1'b0, bus.if_addr[0]};

    lsu_lane_align u_align (
        .func        (bus.d_func),
        .addr_lo     (bus.d_addr[1:0]),
        .store_data  (bus.d_wdata),
        .load_word   (bus.mem_rdata),
        .byte_en     (store_be),
        .store_lanes (store_lanes),
        .load_data   (load_data),
        .misaligned  (lane_fault)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            hold  <= 16'h0;
        end else begin
            state <= state_next;
            if (hold_load) begin
                hold <= bus.mem_rdata[31:16];
            end
        end
    end

    always_comb begin
        state_next    = state;
        hold_load     = 1'b0;
        bus.mem_en    = 1'b0;
        bus.mem_we    = 4'b0000;
        bus.mem_addr  = '0;
        bus.mem_wdata = 32'h0;
        bus.if_ack    = 1'b0;
        bus.if_instr  = 32'h0;
        bus.d_ack     = 1'b0;
        bus.d_rdata   = 32'h0;
        bus.d_err     = 1'b0;

        case (state)
            // Issues are qualified by rst_n so nothing strobes while held in reset.
            ST_IDLE: begin
                if (rst_n) begin
                    if (bus.d_req) begin
                        if (lane_fault) begin
                            state_next = ST_D_ERR;
                        end else begin
                            bus.mem_en   = 1'b1;
                            bus.mem_addr = d_word;
                            if (bus.d_we) begin
                                bus.mem_we    = store_be;
                                bus.mem_wdata = store_lanes;
                            end
                            state_next = ST_D_WAIT;
                        end
                    end else if (bus.if_req) begin
                        bus.mem_en   = 1'b1;
                        bus.mem_addr = if_word;
                        state_next   = bus.if_addr[1] ? ST_F_LO : ST_F_WAIT;
                    end
                end
            end
            ST_D_WAIT: begin
                bus.d_ack = 1'b1;
                if (!bus.d_we) begin
                    bus.d_rdata = load_data;
                end
                state_next = ST_IDLE;
            end
            ST_D_ERR: begin
                bus.d_ack  = 1'b1;
                bus.d_err  = 1'b1;
                state_next = ST_IDLE;
            end
            ST_F_WAIT: begin
                bus.if_ack   = 1'b1;
                bus.if_instr = bus.mem_rdata;
                state_next   = ST_IDLE;
            end
            ST_F_LO: begin
                hold_load = 1'b1;
                if (bus.mem_rdata[17:16] != RVC_FULL) begin
                    bus.if_ack   = 1'b1;
                    bus.if_instr = {16'h0, bus.mem_rdata[31:16]};
                    state_next   = ST_IDLE;
                end else begin
                    bus.mem_en   = 1'b1;
                    bus.mem_addr = if_word_next;
                    state_next   = ST_F_HI;
                end
            end
            ST_F_HI: begin
                bus.if_ack   = 1'b1;
                bus.if_instr = {bus.mem_rdata[15:0], hold};
                state_next   = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a memory model, request drivers and a
// scoreboard monitor that checks every ack against queued expectations.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int AW = 12;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } d_exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    logic [31:0]   mem [0:(1<<AW)-1];
    logic [31:0]   exp_if [$];
    d_exp_t        exp_d [$];
    d_exp_t        d_e;
    logic [31:0]   if_e;
    logic [AW-1:0] iss_addr [$];
    logic [3:0]    iss_we [$];
    logic [31:0]   iss_wdata [$];
    int            iss_cyc [$];
    int            last_if_ack_cyc = 0;
    int            last_d_ack_cyc = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.AW(AW)) bus ();

    mem_port_arbiter #(.AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous single-port memory with byte write strobes.
    always @(posedge clk) begin
        if (bus.mem_en) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.mem_we[b]) mem[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
            end
            bus.mem_rdata <= mem[bus.mem_addr];
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    // Monitor: logs every issue and pops the scoreboard on every ack.
    always @(negedge clk) begin
        if (bus.mem_en) begin
            iss_addr.push_back(bus.mem_addr);
            iss_we.push_back(bus.mem_we);
            iss_wdata.push_back(bus.mem_wdata);
            iss_cyc.push_back(cyc);
        end
        if (bus.d_ack) begin
            last_d_ack_cyc = cyc;
            if (exp_d.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("[TB] FAIL d_ack_unexpected: got d_ack=1 expected no ack");
            end else begin
                d_e = exp_d.pop_front();
                checkOutput("d_rdata", bus.d_rdata, d_e.rdata);
                checkOutput("d_err", 32'(bus.d_err), 32'(d_e.err));
            end
        end
        if (bus.if_ack) begin
            last_if_ack_cyc = cyc;
            if (exp_if.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("[TB] FAIL if_ack_unexpected: got if_ack=1 expected no ack");
            end else begin
                if_e = exp_if.pop_front();
                checkOutput("if_instr", bus.if_instr, if_e);
            end
        end
    end

    task automatic clearLog();
        iss_addr.delete();
        iss_we.delete();
        iss_wdata.delete();
        iss_cyc.delete();
    endtask

    task automatic waitFetchAck(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.if_ack && n < 20);
        if (!bus.if_ack) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL %s_timeout: got no if_ack expected if_ack within 20 cycles", name);
        end
        @(posedge clk);
        #1 bus.if_req = 1'b0;
    endtask

    task automatic waitDataAck(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.d_ack && n < 20);
        if (!bus.d_ack) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL %s_timeout: got no d_ack expected d_ack within 20 cycles", name);
        end
        @(posedge clk);
        #1 bus.d_req = 1'b0;
    endtask

    task automatic applyFetch(input string name, input logic [AW+1:0] addr,
                              input logic [31:0] instr, input int n_iss,
                              input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        int start;
        clearLog();
        start = cyc;
        exp_if.push_back(instr);
        bus.if_addr = addr;
        bus.if_req  = 1'b1;
        waitFetchAck(name);
        @(posedge clk);
        #1;
        checkOutput({name, "_issues"}, 32'(iss_addr.size()), 32'(n_iss));
        checkOutput({name, "_latency"}, 32'(last_if_ack_cyc - start), 32'(n_iss));
        if (iss_addr.size() > 0) checkOutput({name, "_addr0"}, 32'(iss_addr[0]), 32'(a0));
        if (iss_addr.size() > 1) checkOutput({name, "_addr1"}, 32'(iss_addr[1]), 32'(a1));
    endtask

    task automatic applyData(input string name, input logic we, input logic [2:0] func,
                             input logic [AW+1:0] addr, input logic [31:0] wdata,
                             input logic [31:0] rdata, input logic err,
                             input logic [3:0] be, input logic [31:0] lane_mask,
                             input logic [31:0] lanes);
        int start;
        clearLog();
        start = cyc;
        exp_d.push_back('{rdata: rdata, err: err});
        bus.d_we    = we;
        bus.d_func  = func;
        bus.d_addr  = addr;
        bus.d_wdata = wdata;
        bus.d_req   = 1'b1;
        waitDataAck(name);
        @(posedge clk);
        #1;
        checkOutput({name, "_issues"}, 32'(iss_addr.size()), err ? 32'd0 : 32'd1);
        checkOutput({name, "_latency"}, 32'(last_d_ack_cyc - start), 32'd1);
        if (iss_addr.size() > 0) begin
            checkOutput({name, "_addr"}, 32'(iss_addr[0]), 32'(addr[AW+1:2]));
            checkOutput({name, "_we"}, 32'(iss_we[0]), 32'(be));
            checkOutput({name, "_wdata"}, iss_wdata[0] & lane_mask, lanes & lane_mask);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got no finish expected finish before 200000");
        $fatal(1, "[TB] simulation time limit");
    end

    initial begin
        int start;
        for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h0;
        mem[0]     = 32'h0050_0093;
        mem[1]     = 32'h4505_1111;
        mem[12'h40] = 32'h80F0_1234;
        bus.mem_rdata = 32'h0;
        bus.if_req  = 1'b0;
        bus.if_addr = '0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_func  = 3'b000;
        bus.d_addr  = '0;
        bus.d_wdata = 32'h0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_ctrl", {28'h0, bus.if_ack, bus.d_ack, bus.d_err, bus.mem_en}, 32'h0);
        checkOutput("reset_if_instr", bus.if_instr, 32'h0);
        checkOutput("reset_d_rdata", bus.d_rdata, 32'h0);
        checkOutput("reset_mem_we", 32'(bus.mem_we), 32'h0);
        checkOutput("reset_mem_addr", 32'(bus.mem_addr), 32'h0);
        checkOutput("reset_mem_wdata", bus.mem_wdata, 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        applyFetch("fetch_aligned", 14'h0000, 32'h0050_0093, 1, 12'd0, 12'd0);
        applyFetch("fetch_rvc", 14'h0006, 32'h0000_4505, 1, 12'd1, 12'd0);
        mem[1] = 32'h0093_2222;
        mem[2] = 32'h3333_0050;
        applyFetch("fetch_split", 14'h0006, 32'h0050_0093, 2, 12'd1, 12'd2);

        applyData("lb_103", 1'b0, 3'b000, 14'h0103, 32'h0, 32'hFFFF_FF80, 1'b0, 4'h0, 32'h0, 32'h0);
        applyData("lbu_103", 1'b0, 3'b100, 14'h0103, 32'h0, 32'h0000_0080, 1'b0, 4'h0, 32'h0, 32'h0);
        applyData("lh_100", 1'b0, 3'b001, 14'h0100, 32'h0, 32'h0000_1234, 1'b0, 4'h0, 32'h0, 32'h0);
        applyData("lw_100", 1'b0, 3'b010, 14'h0100, 32'h0, 32'h80F0_1234, 1'b0, 4'h0, 32'h0, 32'h0);
        applyData("lbu_101", 1'b0, 3'b100, 14'h0101, 32'h0, 32'h0000_0012, 1'b0, 4'h0, 32'h0, 32'h0);
        applyData("sb_102", 1'b1, 3'b000, 14'h0102, 32'h0000_00AB, 32'h0, 1'b0, 4'b0100,
                  32'h00FF_0000, 32'h00AB_0000);
        applyData("sw_102_err", 1'b1, 3'b010, 14'h0102, 32'h1111_2222, 32'h0, 1'b1, 4'h0, 32'h0, 32'h0);
        applyData("sh_102", 1'b1, 3'b001, 14'h0102, 32'hCAFE_BEEF, 32'h0, 1'b0, 4'b1100,
                  32'hFFFF_0000, 32'hBEEF_0000);
        applyData("lw_after_st", 1'b0, 3'b010, 14'h0100, 32'h0, 32'hBEEF_1234, 1'b0, 4'h0, 32'h0, 32'h0);
        applyData("lh_102", 1'b0, 3'b001, 14'h0102, 32'h0, 32'hFFFF_BEEF, 1'b0, 4'h0, 32'h0, 32'h0);
        applyData("lhu_102", 1'b0, 3'b101, 14'h0102, 32'h0, 32'h0000_BEEF, 1'b0, 4'h0, 32'h0, 32'h0);
        applyData("lh_101_err", 1'b0, 3'b001, 14'h0101, 32'h0, 32'h0, 1'b1, 4'h0, 32'h0, 32'h0);
        applyData("size11_err", 1'b0, 3'b011, 14'h0100, 32'h0, 32'h0, 1'b1, 4'h0, 32'h0, 32'h0);

        // Data and fetch requests raised together: data must be served first.
        clearLog();
        start = cyc;
        exp_d.push_back('{rdata: 32'hBEEF_1234, err: 1'b0});
        exp_if.push_back(32'h0050_0093);
        bus.d_we    = 1'b0;
        bus.d_func  = 3'b010;
        bus.d_addr  = 14'h0100;
        bus.if_addr = 14'h0000;
        bus.d_req   = 1'b1;
        bus.if_req  = 1'b1;
        fork
            waitDataAck("simul_d");
            waitFetchAck("simul_if");
        join
        @(posedge clk);
        #1;
        checkOutput("simul_order", 32'(last_d_ack_cyc < last_if_ack_cyc), 32'd1);
        checkOutput("simul_d_latency", 32'(last_d_ack_cyc - start), 32'd1);
        checkOutput("simul_if_latency", 32'(last_if_ack_cyc - start), 32'd3);
        checkOutput("simul_issues", 32'(iss_addr.size()), 32'd2);
        if (iss_addr.size() > 1) begin
            checkOutput("simul_first_addr", 32'(iss_addr[0]), 32'h40);
            checkOutput("simul_second_addr", 32'(iss_addr[1]), 32'h0);
        end

        mem[(1 << AW) - 1] = 32'h0093_5555;
        mem[0]             = 32'h7777_0050;
        applyFetch("fetch_wrap", 14'h3FFE, 32'h0050_0093, 2, 12'hFFF, 12'h000);

        // Reset asserted while the second half of a split fetch is outstanding.
        bus.if_addr = 14'h0006;
        bus.if_req  = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("fhi_reached", 32'(dut.state == ST_F_HI), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("fhi_rst_state", 32'(dut.state == ST_IDLE), 32'd1);
        checkOutput("fhi_rst_hold", 32'(dut.hold), 32'h0);
        checkOutput("fhi_rst_ctrl", {30'h0, bus.if_ack, bus.mem_en}, 32'h0);
        repeat (2) @(posedge clk);
        #1 bus.if_req = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        applyFetch("fetch_after_rst", 14'h0000, 32'h7777_0050, 1, 12'd0, 12'd0);

        repeat (2) @(posedge clk);
        checkOutput("sb_drain", 32'(exp_if.size() + exp_d.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
